// File: rtl/ntcrack_host_port_if.sv
// ntcrack_host_port_if
//   Byte-serial host pin bundle between the host side and the device-side
//   responder.
//   Signals:
//     new_hash_byte   [7:0]  hash byte from host
//     store_hash_byte        level strobe: "take new_hash_byte"
//     go                     level strobe: start / resume / next password byte
//     my_turn                high when the host may issue the next strobe
//     match_found            high together with my_turn while a password is offered
//     password_byte   [7:0]  current password byte, MSB first
//   Modports:
//     master - host side (drives strobes and data)
//     slave  - device side (drives handshake and password byte)
interface ntcrack_host_port_if;
    logic [7:0] new_hash_byte;
    logic       store_hash_byte;
    logic       go;
    logic       my_turn;
    logic       match_found;
    logic [7:0] password_byte;

    modport master (
        output new_hash_byte,
        output store_hash_byte,
        output go,
        input  my_turn,
        input  match_found,
        input  password_byte
    );

    modport slave (
        input  new_hash_byte,
        input  store_hash_byte,
        input  go,
        output my_turn,
        output match_found,
        output password_byte
    );
endinterface

// File: rtl/ntcrack_host_port.sv
// ntcrack_host_port
//   Device-side responder for the cracker's byte-serial host protocol.
//   Assembles 16-byte target hashes and writes them into the hash table,
//   starts / resumes the search engine on go strobes, and unloads each found
//   password one byte per go strobe, MSB first.
//
//   Ports:
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     host              ntcrack_host_port_if.slave: host strobes and handshake
//     hash_wr_en/idx/data, hash_count
//                       hash table write port and number of complete hashes
//     search_start      one-cycle pulse: search from the beginning
//     search_next       one-cycle pulse: resume after a reported match
//     search_done/match/password
//                       engine result, valid together for one cycle
//     hash_overflow     (only with NTCRACK_HASH_OVERFLOW_EN) sticky flag, set when
//                       a byte is offered while the table is full
//
//   Optional feature macro: NTCRACK_HASH_OVERFLOW_EN
module ntcrack_host_port #(
    parameter int MAX_HASHES = 4,
    parameter int IDX_W      = 2,
    parameter int PW_BYTES   = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ntcrack_host_port_if.slave      host,
    output logic                    hash_wr_en,
    output logic [IDX_W-1:0]        hash_wr_idx,
    output logic [127:0]            hash_wr_data,
    output logic [IDX_W:0]          hash_count,
    output logic                    search_start,
    output logic                    search_next,
    input  logic                    search_done,
    input  logic                    search_match,
    input  logic [8*PW_BYTES-1:0]   search_password
`ifdef NTCRACK_HASH_OVERFLOW_EN
    ,
    output logic                    hash_overflow
`endif
);

    localparam int             PW_W     = 8 * PW_BYTES;
    localparam int             PC_W     = $clog2(PW_BYTES + 1);
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(MAX_HASHES);
    localparam logic [PC_W-1:0] PW_LAST = PC_W'(PW_BYTES - 1);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_LOAD_BUSY,
        ST_SEARCH,
        ST_REPORT,
        ST_REPORT_BUSY,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              store_prev_q, store_prev_d;
    logic              go_prev_q, go_prev_d;
    logic              my_turn_q, my_turn_d;
    logic              match_found_q, match_found_d;
    logic [3:0]        byte_cnt_q, byte_cnt_d;
    logic [127:0]      asm_q, asm_d;
    logic [IDX_W:0]    hash_count_q, hash_count_d;
    logic              wr_en_q, wr_en_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic              start_q, start_d;
    logic              next_q, next_d;
    logic              pend_q, pend_d;
    logic              pend_match_q, pend_match_d;
    logic [PW_W-1:0]   shift_q, shift_d;
    logic [PC_W-1:0]   pw_cnt_q, pw_cnt_d;
`ifdef NTCRACK_HASH_OVERFLOW_EN
    logic              ovf_q, ovf_d;
`endif

    logic store_rise, store_fall, go_rise, go_fall;

    assign store_rise = host.store_hash_byte & ~store_prev_q;
    assign store_fall = ~host.store_hash_byte & store_prev_q;
    assign go_rise    = host.go & ~go_prev_q;
    assign go_fall    = ~host.go & go_prev_q;

    always_comb begin
        state_d       = state_q;
        store_prev_d  = host.store_hash_byte;
        go_prev_d     = host.go;
        my_turn_d     = my_turn_q;
        match_found_d = match_found_q;
        byte_cnt_d    = byte_cnt_q;
        asm_d         = asm_q;
        hash_count_d  = hash_count_q;
        wr_en_d       = 1'b0;
        wr_idx_d      = wr_idx_q;
        start_d       = 1'b0;
        next_d        = 1'b0;
        pend_d        = pend_q;
        pend_match_d  = pend_match_q;
        shift_d       = shift_q;
        pw_cnt_d      = pw_cnt_q;
`ifdef NTCRACK_HASH_OVERFLOW_EN
        ovf_d         = ovf_q;
`endif

        case (state_q)
            ST_LOAD: begin
                // Store has priority over a simultaneous go.
                if (store_rise) begin
                    my_turn_d = 1'b0;
                    state_d   = ST_LOAD_BUSY;
                    if (hash_count_q != FULL_CNT) begin
                        asm_d[{byte_cnt_q, 3'b000} +: 8] = host.new_hash_byte;
                        if (byte_cnt_q == 4'd15) begin
                            wr_en_d      = 1'b1;
                            wr_idx_d     = hash_count_q[IDX_W-1:0];
                            hash_count_d = hash_count_q + 1'b1;
                            byte_cnt_d   = 4'd0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 4'd1;
                        end
                    end else begin
                        // Table full: byte dropped, handshake still completes.
`ifdef NTCRACK_HASH_OVERFLOW_EN
                        ovf_d = 1'b1;
`endif
                    end
                end else if (go_rise) begin
                    byte_cnt_d = 4'd0;  // a partial hash is discarded
                    if (hash_count_q != '0) begin
                        start_d   = 1'b1;
                        my_turn_d = 1'b0;
                        state_d   = ST_SEARCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_LOAD_BUSY: begin
                if (store_fall) begin
                    my_turn_d = 1'b1;
                    state_d   = ST_LOAD;
                end
            end

            ST_SEARCH: begin
                my_turn_d = 1'b0;
                // The result is parked until the host releases go, so a result
                // arriving during the go strobe that started this search is kept.
                // The password goes straight into the shift register; its
                // output is only meaningful once REPORT raises my_turn.
                if (search_done) begin
                    pend_d       = 1'b1;
                    pend_match_d = search_match;
                    shift_d      = search_password;
                end else if (pend_q && !host.go) begin
                    pend_d    = 1'b0;
                    my_turn_d = 1'b1;
                    if (pend_match_q) begin
                        match_found_d = 1'b1;
                        pw_cnt_d      = '0;
                        state_d       = ST_REPORT;
                    end else begin
                        match_found_d = 1'b0;
                        state_d       = ST_DONE;
                    end
                end
            end

            ST_REPORT: begin
                if (go_rise) begin
                    my_turn_d = 1'b0;
                    shift_d   = shift_q << 8;
                    if (pw_cnt_q == PW_LAST) begin
                        next_d        = 1'b1;
                        match_found_d = 1'b0;
                        pw_cnt_d      = '0;
                        state_d       = ST_SEARCH;
                    end else begin
                        pw_cnt_d = pw_cnt_q + PC_W'(1);
                        state_d  = ST_REPORT_BUSY;
                    end
                end
            end

            ST_REPORT_BUSY: begin
                if (go_fall) begin
                    my_turn_d = 1'b1;
                    state_d   = ST_REPORT;
                end
            end

            ST_DONE: begin
                my_turn_d     = 1'b1;
                match_found_d = 1'b0;
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_LOAD;
            store_prev_q  <= 1'b0;
            go_prev_q     <= 1'b0;
            my_turn_q     <= 1'b1;
            match_found_q <= 1'b0;
            byte_cnt_q    <= '0;
            asm_q         <= '0;
            hash_count_q  <= '0;
            wr_en_q       <= 1'b0;
            wr_idx_q      <= '0;
            start_q       <= 1'b0;
            next_q        <= 1'b0;
            pend_q        <= 1'b0;
            pend_match_q  <= 1'b0;
            shift_q       <= '0;
            pw_cnt_q      <= '0;
`ifdef NTCRACK_HASH_OVERFLOW_EN
            ovf_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            store_prev_q  <= store_prev_d;
            go_prev_q     <= go_prev_d;
            my_turn_q     <= my_turn_d;
            match_found_q <= match_found_d;
            byte_cnt_q    <= byte_cnt_d;
            asm_q         <= asm_d;
            hash_count_q  <= hash_count_d;
            wr_en_q       <= wr_en_d;
            wr_idx_q      <= wr_idx_d;
            start_q       <= start_d;
            next_q        <= next_d;
            pend_q        <= pend_d;
            pend_match_q  <= pend_match_d;
            shift_q       <= shift_d;
            pw_cnt_q      <= pw_cnt_d;
`ifdef NTCRACK_HASH_OVERFLOW_EN
            ovf_q         <= ovf_d;
`endif
        end
    end

    assign host.my_turn       = my_turn_q;
    assign host.match_found   = match_found_q;
    assign host.password_byte = shift_q[PW_W-1 -: 8];
    assign hash_wr_en         = wr_en_q;
    assign hash_wr_idx        = wr_idx_q;
    // The assembly register holds the complete hash during the write pulse;
    // it is not touched again until the next store strobe.
    assign hash_wr_data       = asm_q;
    assign hash_count         = hash_count_q;
    assign search_start       = start_q;
    assign search_next        = next_q;
`ifdef NTCRACK_HASH_OVERFLOW_EN
    assign hash_overflow      = ovf_q;
`endif

endmodule

// File: tb/tb_ntcrack_host_port.sv
// tb_ntcrack_host_port
//   Scoreboard bench for ntcrack_host_port. The stimulus process pushes the
//   expected pulses / password bytes into a queue; a monitor on the falling
//   clock edge pops and compares whenever the DUT presents one.
module tb_ntcrack_host_port;

    localparam int PW_BYTES = 20;
    localparam int K_WR = 0, K_START = 1, K_NEXT = 2, K_PW = 3;

    typedef struct {
        int           kind;
        logic [127:0] data;
        int           idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic                   hash_wr_en;
    logic [1:0]             hash_wr_idx;
    logic [127:0]           hash_wr_data;
    logic [2:0]             hash_count;
    logic                   search_start;
    logic                   search_next;
    logic                   search_done = 1'b0;
    logic                   search_match = 1'b0;
    logic [8*PW_BYTES-1:0]  search_password = '0;
`ifdef NTCRACK_HASH_OVERFLOW_EN
    logic                   hash_overflow;
`endif

    ntcrack_host_port_if host_if ();

    ntcrack_host_port #(.MAX_HASHES(4), .IDX_W(2), .PW_BYTES(PW_BYTES)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .host            (host_if),
        .hash_wr_en      (hash_wr_en),
        .hash_wr_idx     (hash_wr_idx),
        .hash_wr_data    (hash_wr_data),
        .hash_count      (hash_count),
        .search_start    (search_start),
        .search_next     (search_next),
        .search_done     (search_done),
        .search_match    (search_match),
        .search_password (search_password)
`ifdef NTCRACK_HASH_OVERFLOW_EN
        ,
        .hash_overflow   (hash_overflow)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   falls  = 0;
    logic mt_prev = 1'b1;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [127:0] data, input int idx);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    // Monitor side: pop and compare one expected event.
    task automatic got(input int kind, input logic [127:0] data, input int idx);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event_kind", 128'(kind), 128'hDEAD);
        end else begin
            e = exp_q.pop_front();
            $display("evt kind=%0d data=%0h idx=%0d t=%0t", kind, data, idx, $time);
            chk("evt_kind", 128'(kind), 128'(e.kind));
            chk("evt_data", data, e.data);
            chk("evt_idx", 128'(idx), 128'(e.idx));
            if (kind == K_WR) chk("wr_hash_count", 128'(hash_count), 128'(e.idx + 1));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (hash_wr_en)   got(K_WR, hash_wr_data, int'(hash_wr_idx));
            if (search_start) got(K_START, 128'd0, 0);
            if (search_next)  got(K_NEXT, 128'd0, 0);
            if (host_if.my_turn && host_if.match_found && !mt_prev)
                got(K_PW, 128'(host_if.password_byte), 0);
            if (!host_if.my_turn && mt_prev) falls++;
        end
        mt_prev = host_if.my_turn;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_turn(input logic v, input string name);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (host_if.my_turn === v) begin
                ok = 1;
                break;
            end
            cyc(1);
        end
        if (!ok) chk(name, 128'(host_if.my_turn), 128'(v));
    endtask

    task automatic store_byte(input logic [7:0] b);
        wait_turn(1'b1, "store_wait_turn");
        host_if.new_hash_byte   = b;
        host_if.store_hash_byte = 1'b1;
        cyc(2);
        host_if.store_hash_byte = 1'b0;
        cyc(1);
        wait_turn(1'b1, "store_done_turn");
    endtask

    task automatic load_hash(input logic [127:0] h, input int idx);
        push(K_WR, h, idx);
        for (int i = 0; i < 16; i++) store_byte(h[8*i +: 8]);
    endtask

    task automatic go_rise();
        host_if.go = 1'b1;
        cyc(2);
    endtask

    task automatic go_fall();
        host_if.go = 1'b0;
        cyc(2);
    endtask

    task automatic raw_strobe(input bit is_go);
        if (is_go) host_if.go = 1'b1; else host_if.store_hash_byte = 1'b1;
        cyc(2);
        host_if.go = 1'b0;
        host_if.store_hash_byte = 1'b0;
        cyc(2);
    endtask

    task automatic fire_done(input logic m, input logic [8*PW_BYTES-1:0] pw);
        search_done     = 1'b1;
        search_match    = m;
        search_password = pw;
        cyc(1);
        search_done     = 1'b0;
        search_match    = 1'b0;
        search_password = '0;
    endtask

    task automatic push_pw(input logic [8*PW_BYTES-1:0] pw, input int n);
        for (int j = 0; j < n; j++) push(K_PW, 128'(pw[8*(PW_BYTES-1-j) +: 8]), 0);
    endtask

    task automatic do_reset();
        host_if.go = 1'b0;
        host_if.store_hash_byte = 1'b0;
        rst_n = 1'b0;
        cyc(2);
        chk("rst_my_turn", 128'(host_if.my_turn), 128'd1);
        chk("rst_match_found", 128'(host_if.match_found), 128'd0);
        chk("rst_password_byte", 128'(host_if.password_byte), 128'd0);
        chk("rst_hash_count", 128'(hash_count), 128'd0);
        chk("rst_pulses", 128'({hash_wr_en, search_start, search_next}), 128'd0);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic report_all(input logic [8*PW_BYTES-1:0] pw);
        for (int k = 0; k < PW_BYTES; k++) begin
            wait_turn(1'b1, "report_wait_turn");
            go_rise();
            go_fall();
        end
        chk("after_report_match_found", 128'(host_if.match_found), 128'd0);
        chk("after_report_my_turn", 128'(host_if.my_turn), 128'd0);
    endtask

    localparam logic [127:0] HASH_A = 128'h588FEB889288FB953B5F094D47D1565C;
    localparam logic [127:0] HASH_B = 128'h91D533DC611AC2774431E2D0BAF36805;
    localparam logic [127:0] HASH_C = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] HASH_D = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;

    logic [8*PW_BYTES-1:0] pw1, pw2;

    initial begin
        host_if.new_hash_byte   = 8'h00;
        host_if.store_hash_byte = 1'b0;
        host_if.go              = 1'b0;
        pw1 = 160'h31003200;
        for (int j = 0; j < PW_BYTES; j++) pw2[8*(PW_BYTES-1-j) +: 8] = 8'(j + 1);

        do_reset();

        // First hash: one write, 16 handshakes.
        falls = 0;
        load_hash(HASH_A, 0);
        chk("hashA_turn_falls", 128'(falls), 128'd16);
        chk("hashA_count", 128'(hash_count), 128'd1);

        // Second hash then go, keep go high while the engine answers.
        load_hash(HASH_B, 1);
        chk("hashB_count", 128'(hash_count), 128'd2);
        push(K_START, 128'd0, 0);
        go_rise();
        chk("search_my_turn", 128'(host_if.my_turn), 128'd0);
        fire_done(1'b1, pw1);
        cyc(3);
        chk("held_my_turn", 128'(host_if.my_turn), 128'd0);
        chk("held_match_found", 128'(host_if.match_found), 128'd0);
        push_pw(pw1, PW_BYTES);
        push(K_NEXT, 128'd0, 0);
        go_fall();
        chk("report_match_found", 128'(host_if.match_found), 128'd1);
        chk("report_my_turn", 128'(host_if.my_turn), 128'd1);
        report_all(pw1);

        // Second match arrives with go already low.
        push_pw(pw2, PW_BYTES);
        push(K_NEXT, 128'd0, 0);
        fire_done(1'b1, pw2);
        cyc(2);
        chk("match2_match_found", 128'(host_if.match_found), 128'd1);
        report_all(pw2);

        // Exhausted: DONE, strobes ignored.
        fire_done(1'b0, '0);
        cyc(2);
        chk("done_my_turn", 128'(host_if.my_turn), 128'd1);
        chk("done_match_found", 128'(host_if.match_found), 128'd0);
        raw_strobe(1'b1);
        raw_strobe(1'b0);
        raw_strobe(1'b1);
        chk("done_still_turn", 128'(host_if.my_turn), 128'd1);
        chk("done_hash_count", 128'(hash_count), 128'd2);

        // Go with an empty table: DONE, no start, later store ignored.
        do_reset();
        raw_strobe(1'b1);
        chk("empty_go_turn", 128'(host_if.my_turn), 128'd1);
        raw_strobe(1'b0);
        chk("empty_go_store_ignored", 128'(hash_count), 128'd0);
        chk("empty_go_turn2", 128'(host_if.my_turn), 128'd1);

        // Partial hash after one full hash is discarded on go.
        do_reset();
        load_hash(HASH_A, 0);
        for (int i = 0; i < 5; i++) store_byte(8'hA0 + 8'(i));
        push(K_START, 128'd0, 0);
        go_rise();
        go_fall();
        chk("partial_hash_count", 128'(hash_count), 128'd1);
        fire_done(1'b0, '0);
        cyc(2);
        chk("partial_done_turn", 128'(host_if.my_turn), 128'd1);

        // Full table, overflow, then reset mid-report.
        do_reset();
        load_hash(HASH_A, 0);
        load_hash(HASH_B, 1);
        load_hash(HASH_C, 2);
        load_hash(HASH_D, 3);
`ifdef NTCRACK_HASH_OVERFLOW_EN
        chk("ovf_before", 128'(hash_overflow), 128'd0);
`endif
        for (int i = 0; i < 16; i++) store_byte(8'h11 * 8'(i));
        chk("full_hash_count", 128'(hash_count), 128'd4);
`ifdef NTCRACK_HASH_OVERFLOW_EN
        chk("ovf_after", 128'(hash_overflow), 128'd1);
`endif
        push(K_START, 128'd0, 0);
        go_rise();
        go_fall();
        push_pw(pw2, 4);
        fire_done(1'b1, pw2);
        cyc(2);
        for (int k = 0; k < 3; k++) begin
            wait_turn(1'b1, "midrpt_wait_turn");
            go_rise();
            go_fall();
        end
        chk("midrpt_match_found", 128'(host_if.match_found), 128'd1);
        do_reset();
`ifdef NTCRACK_HASH_OVERFLOW_EN
        chk("ovf_cleared", 128'(hash_overflow), 128'd0);
`endif

        cyc(3);
        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
